// File: rtl/gate_lane_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gate_arb_pkg
//  Purpose  : Shared types and default constants for the parking gate lane
//             arbiter: FSM state encoding, lane identifiers, default sizing.
//  Revision : 1.0 - initial release
// ============================================================================
package gate_arb_pkg;

  // Default sizing; widths must hold CAPACITY and OPEN_TIMEOUT respectively
  localparam int unsigned C_DEF_CAPACITY     = 16;
  localparam int unsigned C_DEF_CNT_W        = 5;
  localparam int unsigned C_DEF_OPEN_TIMEOUT = 200;
  localparam int unsigned C_DEF_TO_W         = 8;

  // Arbiter states
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    GRANT_ENT  = 3'd1,
    GRANT_EXT  = 3'd2,
    WAIT_CLEAR = 3'd3,
    HALT       = 3'd4
  } arb_state_t;

  // Lane identifiers, used for the round-robin history
  typedef enum logic {
    LANE_ENT = 1'b0,
    LANE_EXT = 1'b1
  } lane_t;

endpackage : gate_arb_pkg
`default_nettype wire

// File: rtl/lane_timeout_timer.sv
`default_nettype none
// ============================================================================
//  Module   : lane_timeout_timer
//  Purpose  : Grant-open timer. Counts enabled cycles from zero and flags the
//             terminal count OPEN_TIMEOUT-1; clear forces it back to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module lane_timeout_timer
  import gate_arb_pkg::*;
#(
  parameter int unsigned OPEN_TIMEOUT = C_DEF_OPEN_TIMEOUT,
  parameter int unsigned TO_W         = C_DEF_TO_W
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [TO_W-1:0] C_TERMINAL = TO_W'(OPEN_TIMEOUT - 1);

  logic [TO_W-1:0] r_count;

  // Count enabled cycles; hold at terminal so a stuck enable never wraps
  always_ff @(posedge Clk) begin
    if (Reset || clear) begin
      r_count <= '0;
    end else if (enable && (r_count != C_TERMINAL)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign terminal = (r_count == C_TERMINAL);

endmodule : lane_timeout_timer
`default_nettype wire

// File: rtl/gate_lane_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : gate_lane_arbiter
//  Purpose  : Shares one parking gate between entry and exit lanes, sequences
//             the open command until the vehicle passes, tracks occupancy and
//             flags a grant that stays open too long. A gate fault halts it.
//  Config   : LANE_ARB_FIXED_PRIO_EN - when defined, IDLE ties always go to
//             the entry lane and no last-grant history is kept; otherwise
//             ties alternate round-robin starting with entry.
//  Revision : 1.0 - initial release
// ============================================================================
module gate_lane_arbiter
  import gate_arb_pkg::*;
#(
  parameter int unsigned CAPACITY     = C_DEF_CAPACITY,
  parameter int unsigned CNT_W        = C_DEF_CNT_W,
  parameter int unsigned OPEN_TIMEOUT = C_DEF_OPEN_TIMEOUT,
  parameter int unsigned TO_W         = C_DEF_TO_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ReqEnt,
  input  logic             ReqExt,
  input  logic             PassDone,
  input  logic             GateFault,
  output logic             GntEnt,
  output logic             GntExt,
  output logic             OpenCmd,
  output logic [CNT_W-1:0] Occupancy,
  output logic             Full,
  output logic             Empty,
  output logic             TimeoutAlarm
);

  localparam logic [CNT_W-1:0] C_CAP = CNT_W'(CAPACITY);

  arb_state_t       r_state;
  logic             r_gnt_ent;
  logic             r_gnt_ext;
  logic             r_open;
  logic             r_alarm;
  logic [CNT_W-1:0] r_occ;
  logic             r_full;
  logic             r_empty;

  logic             w_in_grant;
  logic             w_timeout;
  logic             w_ent_elig;
  logic             w_ext_elig;
  logic             w_ent_wins_tie;
  logic [CNT_W-1:0] w_occ_next;

  // --------------------------------------------------------------------------
  // Grant-open timer: runs only while a lane owns the gate
  // --------------------------------------------------------------------------
  assign w_in_grant = (r_state == GRANT_ENT) || (r_state == GRANT_EXT);

  lane_timeout_timer #(
    .OPEN_TIMEOUT (OPEN_TIMEOUT),
    .TO_W         (TO_W)
  ) u_timer (
    .Clk      (Clk),
    .Reset    (Reset),
    .clear    (!w_in_grant),
    .enable   (w_in_grant),
    .terminal (w_timeout)
  );

  // --------------------------------------------------------------------------
  // Eligibility and tie-break
  // --------------------------------------------------------------------------
  assign w_ent_elig = ReqEnt && !r_full;
  assign w_ext_elig = ReqExt && !r_empty;

`ifdef LANE_ARB_FIXED_PRIO_EN
  assign w_ent_wins_tie = 1'b1;
`else
  lane_t r_last_gnt;
  // Entry wins a tie unless it was the lane served most recently
  assign w_ent_wins_tie = (r_last_gnt == LANE_EXT);
`endif

  // Next occupancy: a completed pass in a grant state moves the count,
  // saturating at both ends; a coincident gate fault suppresses the update
  always_comb begin
    w_occ_next = r_occ;
    if (!GateFault && PassDone) begin
      if (r_state == GRANT_ENT) begin
        w_occ_next = (r_occ >= C_CAP) ? C_CAP : r_occ + 1'b1;
      end else if (r_state == GRANT_EXT) begin
        w_occ_next = (r_occ == '0) ? '0 : r_occ - 1'b1;
      end
    end
  end

  // Occupancy register with registered full/empty flags
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_occ   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_occ   <= w_occ_next;
      r_full  <= (w_occ_next == C_CAP);
      r_empty <= (w_occ_next == '0);
    end
  end

  // Arbitration FSM with registered grant, open and alarm outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_gnt_ent  <= 1'b0;
      r_gnt_ext  <= 1'b0;
      r_open     <= 1'b0;
      r_alarm    <= 1'b0;
`ifndef LANE_ARB_FIXED_PRIO_EN
      r_last_gnt <= LANE_EXT;
`endif
    end else begin
      r_alarm <= 1'b0;
      if (GateFault) begin
        r_state   <= HALT;
        r_gnt_ent <= 1'b0;
        r_gnt_ext <= 1'b0;
        r_open    <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_ent_elig && (!w_ext_elig || w_ent_wins_tie)) begin
              r_state    <= GRANT_ENT;
              r_gnt_ent  <= 1'b1;
              r_open     <= 1'b1;
`ifndef LANE_ARB_FIXED_PRIO_EN
              r_last_gnt <= LANE_ENT;
`endif
            end else if (w_ext_elig) begin
              r_state    <= GRANT_EXT;
              r_gnt_ext  <= 1'b1;
              r_open     <= 1'b1;
`ifndef LANE_ARB_FIXED_PRIO_EN
              r_last_gnt <= LANE_EXT;
`endif
            end
          end

          GRANT_ENT, GRANT_EXT: begin
            // Pass, abandon and timeout all release the gate; only the
            // timeout raises the alarm (count change handled separately)
            if (PassDone || !(r_state == GRANT_ENT ? ReqEnt : ReqExt) || w_timeout) begin
              r_state   <= WAIT_CLEAR;
              r_gnt_ent <= 1'b0;
              r_gnt_ext <= 1'b0;
              r_open    <= 1'b0;
              r_alarm   <= !PassDone && (r_state == GRANT_ENT ? ReqEnt : ReqExt) && w_timeout;
            end
          end

          WAIT_CLEAR: begin
            if (!PassDone) begin
              r_state <= IDLE;
            end
          end

          HALT: begin
            r_state <= IDLE;
          end

          default: begin
            r_state   <= IDLE;
            r_gnt_ent <= 1'b0;
            r_gnt_ext <= 1'b0;
            r_open    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign GntEnt       = r_gnt_ent;
  assign GntExt       = r_gnt_ext;
  assign OpenCmd      = r_open;
  assign TimeoutAlarm = r_alarm;
  assign Occupancy    = r_occ;
  assign Full         = r_full;
  assign Empty        = r_empty;

endmodule : gate_lane_arbiter
`default_nettype wire
